alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Registers the decoded ALU control word and always drives a defined code, so no latches are inferred.
- Flags undefined encodings.
- Adds a multi-cycle sequencer for MUL/DIV that stalls the datapath and drives step strobes to the iterative unit.
- Sits between the main control unit and the 24-bit ALU / mul-div unit.

Parameters:
- FUNC_W, 4, function field width (≥4)
- OPC_W, 4, opcode field width (≥4)
- CTRL_W, 4, ALU control word width (≥4)
- MC_CYCLES, 24, step cycles per MUL/DIV (≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  decode request this cycle
- alu_op  in  2  class from main control: 00 load/store, 01 branch, 10 R-type, 11 immediate
- func  in  FUNC_W  R-type function field
- opcode  in  OPC_W  instruction opcode
- flush  in  1  synchronous abort of the current operation
- alu_ctrl  out  CTRL_W  registered ALU control word
- ctrl_valid  out  1  alu_ctrl is final for this instruction (1-cycle pulse)
- illegal  out  1  undefined encoding (pulses with ctrl_valid)
- stall  out  1  upstream must hold the instruction
- mc_start  out  1  load operands into the mul/div unit (1-cycle pulse)
- mc_step  out  1  mul/div iterate strobe
- mc_last  out  1  final iteration strobe

Behaviour:
- Reset (rst_n=0, async): state=IDLE, counter=0, all outputs 0, alu_ctrl=0.
- States: IDLE, BUSY, DONE. stall, mc_step and mc_last are Moore outputs of registered state; all other outputs are registers.
- Decode table (zero-extended to CTRL_W):
  - alu_op=00 → 0010 (add)
  - alu_op=01 → 1010 (sub)
  - alu_op=10, func:
    - 0000 → 0000 (and)
    - 0001 → 0001 (or)
    - 0010 → 0010 (add)
    - 0011 → 1010 (sub)
    - 0100 → 0011 (slt)
    - 0110 → 0100 (xor)
    - 0111 → 0110 (MUL, multi-cycle)
    - 1000 → 0111 (DIV, multi-cycle)
  - alu_op=11, opcode:
    - 0001 → 0010 (addi)
    - 0010 → 0000 (andi)
    - 0011 → 0001 (ori)
    - 0100 → 0011 (slti)
  - Any other encoding, or nonzero bits of func/opcode above bit 3 → alu_ctrl=0010, illegal=1.
- Accept: valid_in=1 && stall=0 && flush=0 at a rising edge. Accepted in IDLE or DONE.
- Single-cycle op accepted at edge k:
  - During cycle k+1: alu_ctrl set, ctrl_valid=1, illegal per table.
  - State → IDLE.
  - Latency 1. Back-to-back issue every cycle is allowed.
- MUL/DIV accepted at edge k:
  - During cycle k+1: state=BUSY, alu_ctrl set, mc_start=1, counter=MC_CYCLES-1.
  - In BUSY: stall=1 and mc_step=1 every cycle; counter decrements each edge; mc_last=1 when counter==0.
  - The edge after mc_last: state → DONE.
  - DONE lasts 1 cycle: ctrl_valid=1, stall=0, mc_step=0.
  - stall is high for exactly MC_CYCLES cycles; total latency is MC_CYCLES+1.
- No accept is possible while stall=1; valid_in is ignored.
- When not refreshed by a decode, ctrl_valid, illegal and mc_start return to 0 on the next edge. alu_ctrl holds its last value.
- Flush (highest priority):
  - At any edge, flush=1 forces state=IDLE and counter=0.
  - ctrl_valid, illegal and mc_start read 0 the next cycle, and no accept occurs that edge.
  - Flush during BUSY aborts the operation with no ctrl_valid.
- Reset mid-BUSY: immediate return to the reset state; no strobes.
- Counter width is $clog2(MC_CYCLES). No wrap: the counter is reloaded only on a MUL/DIV accept.

Test Plan:
- Reset with valid_in=1 held → all outputs 0. Release rst_n, send alu_op=10, func=0011 → next cycle alu_ctrl=1010, ctrl_valid=1, illegal=0.
- Back-to-back decodes: 00, 01, 11/opcode 0001, 10/0110 on consecutive cycles → alu_ctrl 0010, 1010, 0010, 0100 on consecutive cycles, each with ctrl_valid=1, stall never high.
- MUL (10/0111), MC_CYCLES=24 → mc_start one cycle with alu_ctrl=0110; stall=1 and mc_step=1 for 24 cycles; mc_last on the 24th; ctrl_valid on cycle 25; an instruction held on valid_in is accepted in DONE.
- Illegal: 10/0101, then 11/1111 → each yields alu_ctrl=0010, illegal=1, ctrl_valid=1, no stall.
- DIV (10/1000) with flush at BUSY cycle 5 → next cycle state IDLE, stall=0, no mc_last, no ctrl_valid; the next add decodes normally.
- rst_n pulsed low at BUSY cycle 10 → outputs 0 asynchronously; after release, state IDLE with a fresh accept.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with registered control word, illegal-encoding flag and
// a multi-cycle sequencer that stalls the pipe and strobes the iterative MUL/DIV unit.
module alu_ctrl_seq #(
  parameter int FUNC_W    = 4,
  parameter int OPC_W     = 4,
  parameter int CTRL_W    = 4,
  parameter int MC_CYCLES = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] func,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              flush,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              ctrl_valid,
  output logic              illegal,
  output logic              stall,
  output logic              mc_start,
  output logic              mc_step,
  output logic              mc_last,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(MC_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: an instruction is taken at a rising edge when valid_in=1,
  // stall=0 and flush=0; while stall=1 upstream holds it and valid_in is ignored.

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] alu_ctrl_d;
  logic              ctrl_valid_d, illegal_d, mc_start_d;

  logic [3:0]        dec_code;
  logic              dec_ill;
  logic              dec_mc;

  // Undefined encodings still produce the add code so the ALU never sees garbage.
  always_comb begin
    dec_code = 4'b0010;
    dec_ill  = 1'b0;
    dec_mc   = 1'b0;
    case (alu_op)
      2'b00: dec_code = 4'b0010;
      2'b01: dec_code = 4'b1010;
      2'b10: begin
        if ((func >> 4) != '0) begin
          dec_ill = 1'b1;
        end else begin
          case (func[3:0])
            4'b0000: dec_code = 4'b0000;
            4'b0001: dec_code = 4'b0001;
            4'b0010: dec_code = 4'b0010;
            4'b0011: dec_code = 4'b1010;
            4'b0100: dec_code = 4'b0011;
            4'b0110: dec_code = 4'b0100;
            4'b0111: begin dec_code = 4'b0110; dec_mc = 1'b1; end
            4'b1000: begin dec_code = 4'b0111; dec_mc = 1'b1; end
            default: dec_ill = 1'b1;
          endcase
        end
      end
      default: begin
        if ((opcode >> 4) != '0) begin
          dec_ill = 1'b1;
        end else begin
          case (opcode[3:0])
            4'b0001: dec_code = 4'b0010;
            4'b0010: dec_code = 4'b0000;
            4'b0011: dec_code = 4'b0001;
            4'b0100: dec_code = 4'b0011;
            default: dec_ill = 1'b1;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_ctrl_d   = alu_ctrl;
    ctrl_valid_d = 1'b0;
    illegal_d    = 1'b0;
    mc_start_d   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BUSY: begin
          // Counter parks at zero; it is only reloaded by a new MUL/DIV accept.
          if (cnt_q == '0) begin
            state_d      = DONE;
            ctrl_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          if (valid_in) begin
            alu_ctrl_d = CTRL_W'(dec_code);
            if (dec_mc) begin
              state_d    = BUSY;
              cnt_d      = CNT_W'(MC_CYCLES - 1);
              mc_start_d = 1'b1;
            end else begin
              ctrl_valid_d = 1'b1;
              illegal_d    = dec_ill;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_ctrl   <= '0;
      ctrl_valid <= 1'b0;
      illegal    <= 1'b0;
      mc_start   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_ctrl   <= alu_ctrl_d;
      ctrl_valid <= ctrl_valid_d;
      illegal    <= illegal_d;
      mc_start   <= mc_start_d;
    end
  end

  assign stall     = (state_q == BUSY);
  assign mc_step   = (state_q == BUSY);
  assign mc_last   = (state_q == BUSY) && (cnt_q == '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode table, MUL/DIV sequencing, flush and
// mid-operation reset, with hand-computed expected output words.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [1:0] alu_op;
  logic [3:0] func;
  logic [3:0] opcode;
  logic       flush;
  logic [3:0] alu_ctrl;
  logic       ctrl_valid, illegal, stall, mc_start, mc_step, mc_last;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  alu_ctrl_seq #(.FUNC_W(4), .OPC_W(4), .CTRL_W(4), .MC_CYCLES(24)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_op(alu_op),
    .func(func), .opcode(opcode), .flush(flush), .alu_ctrl(alu_ctrl),
    .ctrl_valid(ctrl_valid), .illegal(illegal), .stall(stall),
    .mc_start(mc_start), .mc_step(mc_step), .mc_last(mc_last),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // {alu_ctrl, ctrl_valid, illegal, stall, mc_start, mc_step, mc_last}
  function automatic logic [9:0] obs();
    return {alu_ctrl, ctrl_valid, illegal, stall, mc_start, mc_step, mc_last};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] f, input logic [3:0] o);
    valid_in = v;
    alu_op   = op;
    func     = f;
    opcode   = o;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b1, 2'b10, 4'b0011, 4'b0000);
    step();
    step();
    chk("reset_obs", 32'(obs()), 32'(10'b0000_000000));
    chk("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("first_sub", 32'(obs()), 32'(10'b1010_100000));

    // back-to-back single-cycle decodes
    drive(1'b1, 2'b00, 4'b0000, 4'b0000);
    step(); chk("b2b_ldst", 32'(obs()), 32'(10'b0010_100000));
    drive(1'b1, 2'b01, 4'b0000, 4'b0000);
    step(); chk("b2b_br", 32'(obs()), 32'(10'b1010_100000));
    drive(1'b1, 2'b11, 4'b0000, 4'b0001);
    step(); chk("b2b_addi", 32'(obs()), 32'(10'b0010_100000));
    drive(1'b1, 2'b10, 4'b0110, 4'b0000);
    step(); chk("b2b_xor", 32'(obs()), 32'(10'b0100_100000));
    drive(1'b0, 2'b00, 4'b0000, 4'b0000);
    step(); chk("idle_hold", 32'(obs()), 32'(10'b0100_000000));

    // MUL: 24 stalled step cycles, then DONE; a held add is taken in DONE
    drive(1'b1, 2'b10, 4'b0111, 4'b0000);
    step(); chk("mul_start", 32'(obs()), 32'(10'b0110_001110));
    drive(1'b1, 2'b00, 4'b0000, 4'b0000);
    for (int c = 2; c <= 24; c++) begin
      step();
      chk($sformatf("mul_busy%0d", c), 32'(obs()),
          32'({4'b0110, 2'b00, 1'b1, 1'b0, 1'b1, (c == 24)}));
    end
    step();
    chk("mul_done", 32'(obs()), 32'(10'b0110_100000));
    chk("mul_done_state", 32'(dbg_state), 32'd2);
    step();
    chk("held_add", 32'(obs()), 32'(10'b0010_100000));
    chk("held_add_state", 32'(dbg_state), 32'd0);

    // illegal encodings
    drive(1'b1, 2'b10, 4'b0101, 4'b0000);
    step(); chk("ill_func", 32'(obs()), 32'(10'b0010_110000));
    drive(1'b1, 2'b11, 4'b0000, 4'b1111);
    step(); chk("ill_opc", 32'(obs()), 32'(10'b0010_110000));
    drive(1'b0, 2'b00, 4'b0000, 4'b0000);
    step(); chk("ill_clear", 32'(obs()), 32'(10'b0010_000000));

    // DIV flushed during BUSY cycle 5
    drive(1'b1, 2'b10, 4'b1000, 4'b0000);
    step(); chk("div_start", 32'(obs()), 32'(10'b0111_001110));
    drive(1'b0, 2'b00, 4'b0000, 4'b0000);
    for (int c = 2; c <= 5; c++) step();
    chk("div_busy5", 32'(obs()), 32'(10'b0111_001010));
    flush = 1'b1;
    drive(1'b1, 2'b00, 4'b0000, 4'b0000);
    step();
    chk("flush_obs", 32'(obs()), 32'(10'b0111_000000));
    chk("flush_state", 32'(dbg_state), 32'd0);
    flush = 1'b0;
    step(); chk("post_flush_add", 32'(obs()), 32'(10'b0010_100000));

    // reset pulsed during MUL BUSY cycle 10
    drive(1'b1, 2'b10, 4'b0111, 4'b0000);
    step();
    drive(1'b0, 2'b00, 4'b0000, 4'b0000);
    for (int c = 2; c <= 10; c++) step();
    chk("mul_busy10", 32'(obs()), 32'(10'b0110_001010));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_obs", 32'(obs()), 32'(10'b0000_000000));
    chk("async_rst_state", 32'(dbg_state), 32'd0);
    step();
    chk("rst_hold_obs", 32'(obs()), 32'(10'b0000_000000));
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'b10, 4'b0001, 4'b0000);
    step(); chk("fresh_or", 32'(obs()), 32'(10'b0001_100000));
    chk("fresh_state", 32'(dbg_state), 32'd0);
    drive(1'b0, 2'b00, 4'b0000, 4'b0000);
    step(); chk("fresh_clear", 32'(obs()), 32'(10'b0001_000000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
